// File: rtl/adc_conv_sequencer_if.sv
// Wrapper/core bus for the ADC conversion sequencer.
interface adc_conv_sequencer_if #(
  parameter int unsigned SAMPLE_WIDTH = 12
);
  logic [31:0]             TRIG_WORD;
  logic [7:0]              CHAN_MASK;
  logic                    POP;
  logic                    adc_done;
  logic [SAMPLE_WIDTH-1:0] adc_data;
  logic [2:0]              amux_sel;
  logic                    adc_start;
  logic                    irq;
  logic [31:0]             STATUS;
  logic [31:0]             MEASUREMENT;

  // Driver side: register wrapper plus ADC core
  modport master (
    output TRIG_WORD, CHAN_MASK, POP, adc_done, adc_data,
    input  amux_sel, adc_start, irq, STATUS, MEASUREMENT
  );

  // Sequencer side
  modport slave (
    input  TRIG_WORD, CHAN_MASK, POP, adc_done, adc_data,
    output amux_sel, adc_start, irq, STATUS, MEASUREMENT
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: walks the enabled mux channels, times settle/start/wait,
// and queues tagged results in a 4-entry FIFO read back through MEASUREMENT.
module adc_conv_sequencer #(
  parameter int unsigned SAMPLE_WIDTH   = 12,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  adc_conv_sequencer_if.slave bus
);
  localparam int unsigned ENTRY_W = 3 + SAMPLE_WIDTH;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // DONE shares STATUS code 0 with IDLE through its low two bits
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         mask_q;
  logic [2:0]         amux_q;
  logic               start_q;
  logic               irq_q;
  logic               busy_q;
  logic               scan_to_q;
  logic               prev_start_q;
  logic               ovf_q;
  logic               timeout_q;
  logic [1:0]         wr_q;
  logic [1:0]         rd_q;
  logic [2:0]         count_q;
  logic [2:0]         count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               trig_c;
  logic               push_c;
  logic               pop_c;
  logic               push_ok_c;
  logic               ovf_evt_c;
  logic               to_evt_c;
  logic [3:0]         nxt_c;
  logic [ENTRY_W-1:0] head_c;
  logic [31:0]        meas_c;

  // Reserved trigger bits
  logic unused_trig;
  assign unused_trig = ^bus.TRIG_WORD[31:3];

  function automatic logic [2:0] lowest_chan(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // {found, index} of the lowest enabled channel above cur
  function automatic logic [3:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    return r;
  endfunction

  // Trigger edge, FIFO push/pop arbitration and flag events
  always_comb begin
    trig_c    = bus.TRIG_WORD[0] && !prev_start_q;
    push_c    = (state_q == S_WAIT) && bus.adc_done;
    pop_c     = bus.POP && (count_q != 3'd0);
    push_ok_c = push_c && ((count_q != 3'(DEPTH)) || pop_c);
    ovf_evt_c = push_c && !push_ok_c;
    to_evt_c  = (state_q == S_WAIT) && !bus.adc_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    nxt_c     = next_chan(mask_q, amux_q);
    count_d   = count_q + 3'(push_ok_c) - 3'(pop_c);
  end

  // Scan sequencer with registered start/irq/busy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      amux_q       <= '0;
      start_q      <= 1'b0;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      scan_to_q    <= 1'b0;
      prev_start_q <= 1'b1;
    end else begin
      prev_start_q <= bus.TRIG_WORD[0];
      start_q      <= 1'b0;
      irq_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trig_c && (bus.CHAN_MASK != 8'd0)) begin
            mask_q    <= bus.CHAN_MASK;
            amux_q    <= lowest_chan(bus.CHAN_MASK);
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            scan_to_q <= 1'b0;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_q   <= '0;
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.adc_done) begin
            if (nxt_c[3]) begin
              amux_q  <= nxt_c[2:0];
              cnt_q   <= '0;
              state_q <= S_SETTLE;
            end else begin
              busy_q  <= 1'b0;
              irq_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (to_evt_c) begin
            scan_to_q <= 1'b1;
            busy_q    <= 1'b0;
            irq_q     <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.TRIG_WORD[1] && !scan_to_q && (bus.CHAN_MASK != 8'd0)) begin
            mask_q  <= bus.CHAN_MASK;
            amux_q  <= lowest_chan(bus.CHAN_MASK);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky flags (clear wins over set)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (push_ok_c) wr_q <= wr_q + 2'd1;
      if (pop_c) rd_q <= rd_q + 2'd1;
      count_q <= count_d;
      if (bus.TRIG_WORD[2]) ovf_q <= 1'b0;
      else if (ovf_evt_c) ovf_q <= 1'b1;
      if (bus.TRIG_WORD[2]) timeout_q <= 1'b0;
      else if (to_evt_c) timeout_q <= 1'b1;
    end
  end

  // FIFO storage: channel tag above the sample
  always_ff @(posedge clk) begin
    if (push_ok_c && !reset) mem_q[wr_q] <= {amux_q, bus.adc_data};
  end

  // Head-of-FIFO read word, zero when empty
  always_comb begin
    head_c = mem_q[rd_q];
    meas_c = '0;
    if (count_q != 3'd0) begin
      meas_c[31]                 = 1'b1;
      meas_c[18:16]              = head_c[ENTRY_W-1 -: 3];
      meas_c[SAMPLE_WIDTH-1:0]   = head_c[SAMPLE_WIDTH-1:0];
    end
  end

  assign bus.amux_sel    = amux_q;
  assign bus.adc_start   = start_q;
  assign bus.irq         = irq_q;
  assign bus.STATUS      = {18'd0, state_q[1:0], 1'b0, amux_q, 2'd0, timeout_q, ovf_q, count_q, busy_q};
  assign bus.MEASUREMENT = meas_c;
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer against a transaction-level scan/FIFO model.
module tb_adc_conv_sequencer;
  localparam int unsigned SW = 12;
  localparam int unsigned SC = 8;
  localparam int unsigned TO = 255;

  logic clk = 1'b0;
  logic reset;

  adc_conv_sequencer_if #(.SAMPLE_WIDTH(SW)) bus ();

  adc_conv_sequencer #(
    .SAMPLE_WIDTH(SW), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int irq_cnt = 0;

  // Model: FIFO contents as {chan, sample}, plus sticky flags
  logic [14:0] fq[$];
  bit ovf_m = 1'b0;
  bit to_m  = 1'b0;

  always @(negedge clk) if (bus.irq === 1'b1) irq_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_meas();
    logic [31:0] m;
    m = '0;
    if (fq.size() != 0) begin
      m[31]    = 1'b1;
      m[18:16] = fq[0][14:12];
      m[11:0]  = fq[0][11:0];
    end
    return m;
  endfunction

  function automatic logic [31:0] exp_status(input bit busy, input logic [1:0] st, input logic [2:0] ch);
    logic [31:0] s;
    s = '0;
    s[0]     = busy;
    s[3:1]   = 3'(fq.size());
    s[4]     = ovf_m;
    s[5]     = to_m;
    s[10:8]  = ch;
    s[13:12] = st;
    return s;
  endfunction

  function automatic logic [2:0] low_of(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  task automatic m_push(input logic [2:0] ch, input logic [11:0] d, input bit pop);
    if (pop && fq.size() != 0) void'(fq.pop_front());
    if (fq.size() < 4) fq.push_back({ch, d});
    else ovf_m = 1'b1;
  endtask

  task automatic do_pop();
    bus.POP = 1'b1;
    tick();
    bus.POP = 1'b0;
    if (fq.size() != 0) void'(fq.pop_front());
    check_eq("pop_head", bus.MEASUREMENT, exp_meas());
  endtask

  // One scan of mask; ADC answers dly cycles after start (0 = random 1..4)
  task automatic scan(input logic [7:0] mask, input logic [7:0] nxt, input bit trig,
                      input bit cont, input bit pop_done, input int fixed, input int dly);
    int hi, n, dl, irq0;
    logic [11:0] d;
    bit poke, pd;
    hi = 0;
    for (int c = 0; c < 8; c++) if (mask[c]) hi = c;
    irq0 = irq_cnt;
    if (trig) begin
      bus.CHAN_MASK = mask;
      bus.TRIG_WORD = {30'd0, cont, 1'b1};
      tick();
    end
    bus.TRIG_WORD = {30'd0, cont, 1'b0};
    bus.CHAN_MASK = nxt;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        check_eq("settle_status", bus.STATUS, exp_status(1'b1, 2'd1, 3'(c)));
        n = 0;
        while (bus.adc_start !== 1'b1 && n < 64) begin
          tick();
          n++;
        end
        check_eq("start_latency", 32'(n), 32'(SC));
        check_eq("start_sel", 32'(bus.amux_sel), 32'(c));
        d    = (fixed >= 0) ? 12'(fixed) : 12'($urandom);
        dl   = (dly > 0) ? dly : int'($urandom_range(4, 1));
        poke = ($urandom_range(3, 0) == 0);
        for (int k = 0; k < dl; k++) begin
          bus.TRIG_WORD[0] = poke && (k == 0);
          tick();
          if (k == 0) check_eq("start_pulse", 32'(bus.adc_start), 32'd0);
        end
        bus.TRIG_WORD[0] = 1'b0;
        pd = pop_done && (c == hi);
        bus.adc_done = 1'b1;
        bus.adc_data = d;
        bus.POP      = pd;
        tick();
        bus.adc_done = 1'b0;
        bus.POP      = 1'b0;
        bus.adc_data = 12'($urandom);
        m_push(3'(c), d, pd);
        check_eq("head", bus.MEASUREMENT, exp_meas());
      end
    end
    check_eq("end_status", bus.STATUS, exp_status(1'b0, 2'd0, 3'(hi)));
    check_eq("end_irq", 32'(bus.irq), 32'd1);
    tick();
    if (cont && nxt != 8'd0)
      check_eq("restart_status", bus.STATUS, exp_status(1'b1, 2'd1, low_of(nxt)));
    else
      check_eq("idle_status", bus.STATUS, exp_status(1'b0, 2'd0, 3'(hi)));
    check_eq("irq_count", 32'(irq_cnt - irq0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, irq0, np;
    logic [7:0] m, nx;
    bit cm;

    reset         = 1'b1;
    bus.TRIG_WORD = '0;
    bus.CHAN_MASK = '0;
    bus.POP       = 1'b0;
    bus.adc_done  = 1'b0;
    bus.adc_data  = '0;
    repeat (3) tick();
    check_eq("rst_status", bus.STATUS, 32'd0);
    check_eq("rst_meas", bus.MEASUREMENT, 32'd0);
    check_eq("rst_outs", {27'd0, bus.amux_sel, bus.adc_start, bus.irq}, 32'd0);
    reset = 1'b0;
    tick();

    // Single channel, fixed sample
    scan(8'h04, 8'h04, 1'b1, 1'b0, 1'b0, 'hABC, 2);
    check_eq("single_meas", bus.MEASUREMENT, 32'h8002_0ABC);
    check_eq("single_count", 32'(bus.STATUS[3:1]), 32'd1);

    // Channels 0 and 7, then drain and pop on empty
    scan(8'h81, 8'h5A, 1'b1, 1'b0, 1'b0, -1, 0);
    repeat (4) do_pop();
    check_eq("drained", bus.STATUS, exp_status(1'b0, 2'd0, 3'd7));

    // Zero mask trigger is ignored
    irq0 = irq_cnt;
    bus.CHAN_MASK = 8'h00;
    bus.TRIG_WORD = 32'h1;
    tick();
    bus.TRIG_WORD = 32'h0;
    repeat (3) tick();
    check_eq("zmask_busy", 32'(bus.STATUS[0]), 32'd0);
    check_eq("zmask_irq", 32'(irq_cnt - irq0), 32'd0);

    // Overflow then clear
    scan(8'h3F, 8'h00, 1'b1, 1'b0, 1'b0, -1, 0);
    check_eq("ovf_count", 32'(bus.STATUS[3:1]), 32'd4);
    check_eq("ovf_flag", 32'(bus.STATUS[4]), 32'd1);
    bus.TRIG_WORD = 32'h4;
    tick();
    bus.TRIG_WORD = 32'h0;
    ovf_m = 1'b0;
    check_eq("ovf_clear", 32'(bus.STATUS[4]), 32'd0);

    // Full FIFO with coincident pop
    scan(8'h01, 8'h01, 1'b1, 1'b0, 1'b1, -1, 0);
    check_eq("fullpop_count", 32'(bus.STATUS[3:1]), 32'd4);
    check_eq("fullpop_ovf", 32'(bus.STATUS[4]), 32'd0);
    repeat (4) do_pop();

    // Continuous restart with re-latched mask, then stop
    scan(8'h02, 8'h0C, 1'b1, 1'b1, 1'b0, -1, 0);
    scan(8'h0C, 8'h10, 1'b0, 1'b0, 1'b0, -1, 0);
    repeat (2) do_pop();

    // Timeout in continuous mode: no restart
    irq0 = irq_cnt;
    bus.CHAN_MASK = 8'h02;
    bus.TRIG_WORD = 32'h3;
    tick();
    bus.TRIG_WORD = 32'h2;
    n = 0;
    while (bus.adc_start !== 1'b1 && n < 64) begin tick(); n++; end
    check_eq("to_start_latency", 32'(n), 32'(SC));
    n = 0;
    while (bus.irq !== 1'b1 && n < 400) begin tick(); n++; end
    check_eq("to_irq_delay", 32'(n), 32'(TO + 1));
    to_m = 1'b1;
    check_eq("to_status", bus.STATUS, exp_status(1'b0, 2'd0, 3'd1));
    repeat (20) tick();
    check_eq("to_no_restart", bus.STATUS, exp_status(1'b0, 2'd0, 3'd1));
    check_eq("to_irq_count", 32'(irq_cnt - irq0), 32'd1);
    bus.TRIG_WORD = 32'h4;
    tick();
    bus.TRIG_WORD = 32'h0;
    to_m = 1'b0;
    check_eq("to_clear", 32'(bus.STATUS[5]), 32'd0);

    // Reset during WAIT, then a late adc_done
    bus.CHAN_MASK = 8'h01;
    bus.TRIG_WORD = 32'h1;
    tick();
    bus.TRIG_WORD = 32'h0;
    n = 0;
    while (bus.adc_start !== 1'b1 && n < 64) begin tick(); n++; end
    tick();
    reset = 1'b1;
    tick();
    fq.delete();
    ovf_m = 1'b0;
    to_m  = 1'b0;
    check_eq("midrst_status", bus.STATUS, 32'd0);
    check_eq("midrst_outs", {27'd0, bus.amux_sel, bus.adc_start, bus.irq}, 32'd0);
    reset = 1'b0;
    bus.adc_done = 1'b1;
    bus.adc_data = 12'h5A5;
    tick();
    bus.adc_done = 1'b0;
    check_eq("late_done_status", bus.STATUS, 32'd0);
    check_eq("late_done_meas", bus.MEASUREMENT, 32'd0);

    // Start bit held high through reset never fires
    bus.CHAN_MASK = 8'hFF;
    bus.TRIG_WORD = 32'h1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check_eq("held_trig", bus.STATUS, 32'd0);
    bus.TRIG_WORD = 32'h0;
    tick();

    // Randomized scans
    for (int it = 0; it < 14; it++) begin
      np = int'($urandom_range(3, 0));
      for (int p = 0; p < np; p++) do_pop();
      if ($urandom_range(3, 0) == 0) begin
        bus.TRIG_WORD = 32'h4;
        tick();
        bus.TRIG_WORD = 32'h0;
        ovf_m = 1'b0;
        to_m  = 1'b0;
        check_eq("rand_clear", 32'(bus.STATUS[5:4]), 32'd0);
      end
      m  = 8'($urandom_range(255, 1));
      nx = 8'($urandom);
      cm = ($urandom_range(2, 0) == 0);
      scan(m, nx, 1'b1, cm, 1'($urandom_range(1, 0)), -1, 0);
      if (cm && nx != 8'd0) scan(nx, 8'($urandom), 1'b0, 1'b0, 1'b0, -1, 0);
      bus.TRIG_WORD = 32'h0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/adc_conv_sequencer.md
# adc_conv_sequencer

- Sits between the ADC APB register wrapper and the ADC/analog-mux core.
- Turns the wrapper's held trigger and channel-select words into timed conversions: selects mux channel, waits settle, issues a start pulse, captures the result.
- Results go into a 4-entry FIFO with channel tags, surfaced as the wrapper's status and measurement read words.

## Interface
- SAMPLE_WIDTH, 12, ADC result width
- SETTLE_CYCLES, 8, mux settle cycles before each start (≥1)
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- TRIG_WORD  in  32  wrapper trigger register: [0] start (rising edge), [1] continuous, [2] clear sticky flags (level)
- CHAN_MASK  in  8  wrapper amux register [7:0]; bit n enables channel n
- POP  in  1  one-cycle strobe: wrapper consumed MEASUREMENT
- adc_done  in  1  core result valid, one cycle
- adc_data  in  SAMPLE_WIDTH  core result, valid with adc_done
- amux_sel  out  3  analog mux channel
- adc_start  out  1  one-cycle conversion request
- irq  out  1  one-cycle scan-complete/abort pulse
- STATUS  out  32  [0] busy, [3:1] fifo count 0–4, [4] overflow, [5] timeout, [10:8] amux_sel, [13:12] state, others 0
- MEASUREMENT  out  32  [31] valid (fifo non-empty), [18:16] head channel, [SAMPLE_WIDTH-1:0] head sample, others 0

## Operation
- States (STATUS[13:12]): IDLE=0, SETTLE=1, START=2, WAIT=3; DONE is encoded 0 and has busy=0.
- Edge detect: prev_start register, resets to 1; trigger when TRIG_WORD[0]=1 and prev_start=0. A bit held high through reset never fires.
- IDLE, trigger, CHAN_MASK≠0:
  - latch mask
  - amux_sel ← lowest set channel
  - go to SETTLE
- IDLE, trigger, CHAN_MASK=0: ignored; no irq.
- Trigger outside IDLE: ignored.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to START.
- START: adc_start=1 for exactly one cycle, then WAIT. The WAIT counter is cleared.
- WAIT, adc_done=1:
  - push {amux_sel, adc_data}
  - if a higher channel is set in the latched mask: amux_sel ← next higher set channel, go to SETTLE
  - else: go to DONE
- WAIT, no adc_done for TIMEOUT_CYCLES cycles: set timeout flag, go to DONE, discard continuous mode for this run.
- adc_done outside WAIT: ignored.
- DONE: irq=1 for one cycle.
  - If TRIG_WORD[1]=1 and no timeout this scan: re-latch CHAN_MASK. If non-zero, restart at the lowest channel in SETTLE; otherwise go to IDLE.
  - Else: go to IDLE.
- busy=1 in SETTLE/START/WAIT only.
- FIFO: 4 entries, each 3+SAMPLE_WIDTH bits; MEASUREMENT shows the head combinationally.
  - POP on empty: no effect.
  - Push when full without POP: new sample dropped, overflow flag set.
  - Push and POP in the same cycle when full: both happen, no overflow.
  - Push and POP in the same cycle when empty: push only.
- Sticky flags (overflow, timeout): set by events, held at 0 while TRIG_WORD[2]=1. Clear wins over a same-cycle set.
- Reset: all outputs 0, FIFO empty, flags 0, state IDLE, counters 0, prev_start=1.
  - Reset mid-scan aborts immediately; adc_start is low on the next cycle.
  - A late adc_done after reset is ignored.

## Timing
- Trigger sampled in cycle T; amux_sel and busy valid from T+1.
- SETTLE occupies T+1…T+SETTLE_CYCLES; adc_start is high in cycle T+SETTLE_CYCLES+1.
- adc_done in cycle D:
  - entry visible on MEASUREMENT and count incremented at D+1
  - next channel's amux_sel at D+1, or irq=1 at D+1
- Last channel: busy low at D+1, IDLE at D+2. Continuous restart: SETTLE entered at D+2.
- Timeout: last WAIT cycle is start+TIMEOUT_CYCLES; irq and timeout flag at the following cycle.
- POP in cycle P: next head (or valid=0) at P+1.
- All outputs are registered except MEASUREMENT, which is a FIFO-head mux off registers.

## Test plan
- Single-channel scan:
  - Stimulus: reset, CHAN_MASK=0x04, TRIG_WORD=0x1; adc_done with adc_data=0xABC two cycles after adc_start.
  - Required: amux_sel=2; adc_start at T+9; irq at D+1; MEASUREMENT=0x8002_0ABC; STATUS count=1.
- Multi-channel scan:
  - Stimulus: CHAN_MASK=0x81, one trigger.
  - Required: channels 0 then 7, each preceded by 8 settle cycles; exactly one irq; two FIFO entries in order.
- Overflow:
  - Stimulus: CHAN_MASK=0x3F, no POPs.
  - Required: count=4, overflow=1, first four samples retained.
  - Then TRIG_WORD[2]=1 for one cycle: overflow=0.
- Full FIFO with POP:
  - Stimulus: full FIFO, POP coincident with push.
  - Required: count stays 4, overflow stays 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=255, continuous mode, adc_done never asserted.
  - Required: timeout=1 and irq 256 cycles after adc_start; return to IDLE; no restart.
- Mid-scan events:
  - Stimulus: reset asserted during WAIT, then adc_done; trigger pulsed while busy; TRIG_WORD[0] held high through reset.
  - Required: STATUS=0, no push, no spurious scan after reset, busy-time trigger ignored.
